// File: rtl/alu_ctrl_pkg.sv
// Shared opcode encodings, flag positions, FSM states and the per-opcode PSR commit rules
// for the ALU execution controller.
package alu_ctrl_pkg;

  localparam int RA_W = 4;

  // Operation kinds: the opext code of a register form equals the op nibble of its immediate twin.
  localparam logic [3:0] OP_REG = 4'h0;
  localparam logic [3:0] K_WAIT = 4'h0;
  localparam logic [3:0] K_AND  = 4'h1;
  localparam logic [3:0] K_OR   = 4'h2;
  localparam logic [3:0] K_XOR  = 4'h3;
  localparam logic [3:0] K_LSH  = 4'h4;
  localparam logic [3:0] K_ADD  = 4'h5;
  localparam logic [3:0] K_ADDU = 4'h6;
  localparam logic [3:0] K_ADDC = 4'h7;
  localparam logic [3:0] K_RSH  = 4'h8;
  localparam logic [3:0] K_SUB  = 4'h9;
  localparam logic [3:0] K_SUBC = 4'hA;
  localparam logic [3:0] K_CMP  = 4'hB;
  localparam logic [3:0] K_ARSH = 4'hC;
  localparam logic [3:0] K_MOV  = 4'hD;
  localparam logic [3:0] K_MUL  = 4'hE;
  localparam logic [3:0] K_NOT  = 4'hF;
  localparam logic [3:0] OP_ADDUI = K_ADDU;

  localparam int FL_L = 4;
  localparam int FL_C = 3;
  localparam int FL_F = 2;
  localparam int FL_Z = 1;
  localparam int FL_N = 0;

  // Masks laid out as {L, C, F, Z, N}.
  localparam logic [4:0] MASK_ARITH = 5'b11111;
  localparam logic [4:0] MASK_MUL   = 5'b01011;
  localparam logic [4:0] MASK_LOGIC = 5'b00011;
  localparam logic [4:0] MASK_CMP   = 5'b10011;
  localparam logic [4:0] MASK_NONE  = 5'b00000;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;

  function automatic logic [3:0] op_kind(input logic [7:0] op8);
    return (op8[7:4] == OP_REG) ? op8[3:0] : op8[7:4];
  endfunction

  function automatic logic is_illegal(input logic [7:0] op8);
    return op_kind(op8) == K_SUBC;
  endfunction

  function automatic logic writes_rd(input logic [7:0] op8);
    return !(is_illegal(op8) || op_kind(op8) == K_CMP || op8 == {OP_REG, K_WAIT});
  endfunction

  function automatic logic [4:0] psr_mask(input logic [7:0] op8);
    logic [4:0] m;
    m = MASK_NONE;
    case (op_kind(op8))
      K_ADD, K_ADDU, K_ADDC, K_SUB: m = MASK_ARITH;
      K_MUL:                        m = MASK_MUL;
      K_LSH, K_RSH, K_ARSH:         m = MASK_LOGIC;
      K_AND, K_OR, K_XOR, K_NOT:    m = (op8[7:4] == OP_REG) ? MASK_LOGIC : MASK_NONE;
      K_CMP:                        m = MASK_CMP;
      default:                      m = MASK_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/regfile16x16.sv
// 16-entry register file: two combinational read ports, a combinational debug read port,
// one synchronous write port and a synchronous active-low clear.
module regfile16x16
  import alu_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int W     = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [W-1:0]    wdata,
  input  logic [RA_W-1:0] raddr_a,
  input  logic [RA_W-1:0] raddr_b,
  output logic [W-1:0]    rdata_a,
  output logic [W-1:0]    rdata_b,
  input  logic [RA_W-1:0] dbg_addr,
  output logic [W-1:0]    dbg_data
);

  logic [W-1:0] mem_q [NREGS];
  logic [W-1:0] mem_d [NREGS];

  assign rdata_a  = mem_q[raddr_a];
  assign rdata_b  = mem_q[raddr_b];
  assign dbg_data = mem_q[dbg_addr];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Three-state (IDLE/EXEC/WB) controller sequencing one instruction through an external
// combinational ALU; retires every 3 cycles with masked PSR commit and sticky illegal-op error.
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [15:0]  in_instr,
  output logic         in_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [7:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [4:0]   psr,
  output logic         done,
  output logic         err,
  input  logic [3:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  state_t       state_q, state_d;
  logic [15:0]  ir_q, ir_d;
  logic [W-1:0] res_q, res_d;
  logic [4:0]   flg_q, flg_d;
  logic [4:0]   psr_q, psr_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         rf_we;
  logic [W-1:0] rd_val, rs_val, imm_ext;
  logic [4:0]   commit_mask;

  regfile16x16 #(.NREGS(NREGS), .W(W)) u_rf (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (rf_we),
    .waddr    (ir_q[11:8]),
    .wdata    (res_q),
    .raddr_a  (ir_q[11:8]),
    .raddr_b  (ir_q[3:0]),
    .rdata_a  (rd_val),
    .rdata_b  (rs_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Operands are driven from ir in every state, not only during EXEC.
  assign alu_op      = {ir_q[15:12], ir_q[7:4]};
  assign imm_ext     = (ir_q[15:12] == OP_ADDUI) ? {{(W-8){1'b0}}, ir_q[7:0]}
                                                 : {{(W-8){ir_q[7]}}, ir_q[7:0]};
  assign alu_a       = rd_val;
  assign alu_b       = (ir_q[15:12] == OP_REG) ? rs_val : imm_ext;
  assign commit_mask = psr_mask(alu_op);
  assign in_ready    = (state_q == ST_IDLE);
  assign psr         = psr_q;
  assign done        = done_q;
  assign err         = err_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    res_d   = res_q;
    flg_d   = flg_q;
    psr_d   = psr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ir_d    = in_instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_result;
        flg_d   = alu_flags;
        state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_illegal(alu_op)) begin
          err_d = 1'b1;
        end else begin
          rf_we = writes_rd(alu_op);
          // Unmasked flag bits never reach psr, so undefined ALU flags cannot leak in.
          psr_d = (psr_q & ~commit_mask) | (flg_q & commit_mask);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      psr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      psr_q   <= psr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execution controller that sequences the team's 16-bit combinational ALU against a 16x16 register file and a processor status register (PSR). It accepts one CR16-format instruction word at a time over a valid/ready handshake. It then:
- reads the source and destination registers and drives the external ALU;
- writes the result back and commits the flags with per-class masking.

It sits between the instruction source (test harness now, fetch/decode later) and the ALU.

## Interface
Parameters:
- `NREGS`, 16: register count (fixed 16; 4-bit register fields).
- `W`, 16: datapath width.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: instruction word present.
- `in_instr` in 16: fields `[15:12]` op, `[11:8]` Rdest, `[7:4]` opext/imm-hi, `[3:0]` Rsrc/imm-lo.
- `in_ready` out 1: controller can accept an instruction.
- `alu_a` out 16: ALU input A (Rdest value).
- `alu_b` out 16: ALU input B (Rsrc value or extended immediate).
- `alu_op` out 8: ALU opcode.
- `alu_result` in 16: ALU result, combinational from `alu_a`/`alu_b`/`alu_op`.
- `alu_flags` in 5: ALU flags, bit 4 = L, bit 3 = C, bit 2 = F, bit 1 = Z, bit 0 = N.
- `psr` out 5: committed flags, same bit map.
- `done` out 1: one-cycle pulse when an instruction retires.
- `err` out 1: sticky, set by an illegal opcode.
- `dbg_addr` in 4: debug register select.
- `dbg_data` out 16: `rf[dbg_addr]`, combinational.

## Operation
- **FSM states:** IDLE, EXEC, WB.
  - IDLE → EXEC on `in_valid && in_ready`; the instruction word is latched into `ir`.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- **`in_ready`:** equals (state == IDLE). Holding `in_valid` high with no handshake has no effect.
- **ALU opcode:** `alu_op = {ir[15:12], ir[7:4]}`. Register forms have op = 0000; immediate forms carry the imm high nibble in bits `[3:0]`.
- **Operands:**
  - `alu_a = rf[ir[11:8]]`.
  - Register form: `alu_b = rf[ir[3:0]]`.
  - Immediate form: `alu_b` is the extended `ir[7:0]`. ADDUI (op 0110) zero-extends; every other immediate sign-extends.
- **EXEC:** the ALU outputs are captured into `res_q` / `flg_q` at the end of EXEC.
- **WB:** `rf[Rdest] <= res_q`, except for CMP/CMPI, WAIT, and illegal opcodes.
- **PSR commit masks** (unmasked bits keep their old value; X values from the ALU are never latched):
  - ADD/ADDI/ADDU/ADDUI/ADDC/ADDCI/SUB/SUBI: L, C, F, Z, N.
  - MUL/MULI: C, Z, N.
  - AND/OR/XOR/NOT, LSH/LSHI, RSH/RSHI, ARSH/ARSHI: Z, N.
  - CMP/CMPI: L, Z, N.
  - MOV/MOVI, WAIT: none.
- **Illegal opcodes:** op = 0000 with opext 0000 is WAIT. SUBC/SUBCI (ext 1010 / op 1010) are illegal because the ALU does not implement them. An illegal opcode causes no write and no PSR change, sets `err`, and still pulses `done`.
- **Register aliasing:** Rdest == Rsrc is legal. R0 is a normal writable register.
- **Outside EXEC:** `alu_a`, `alu_b` and `alu_op` still reflect `ir`. Downstream logic must not assume they are zero.

## Timing
- **Reset values:** all `rf` entries 0, `ir` = 0, `psr` = 0, `done` = 0, `err` = 0, state = IDLE, `in_ready` = 1 (next cycle after reset deasserts).
- **Latency:**
  - Handshake at edge N.
  - EXEC during cycle N+1.
  - `rf`/`psr`/`done` update at edge N+2.
  - `in_ready` returns high after edge N+2.
  - Throughput: 1 instruction per 3 cycles.
- **`done`:** high exactly during the cycle after edge N+2 (registered).
- **Debug port:** `dbg_data` shows the new value from the cycle after the WB edge.
- **Reset mid-operation:** `reset_n` low in EXEC or WB aborts the instruction. No write, no `done`, and all state returns to reset values.
- **Errors:** `err` clears only on reset.

## Structure
- **Package `alu_ctrl_pkg`:**
  - Opcode localparams (op nibbles and opext codes).
  - Flag bit indices L = 4, C = 3, F = 2, Z = 1, N = 0.
  - State enum.
  - Function returning the 5-bit PSR commit mask for an 8-bit opcode.
- **Sub-module `regfile16x16`:**
  - Two combinational read ports plus a debug read port.
  - One synchronous write port.
  - Synchronous active-low clear.
- **Top level:** FSM, `ir`, `res_q`, `flg_q`, PSR and `err`.
- **Test bench:** instantiates the team ALU on the `alu_*` ports.

## Test plan
- **Reset and MOVI:** Reset, then MOVI R1, 0x7F (`0xD17F`) → `rf[1]` = 0x007F, `psr` unchanged 0, `done` pulses at N+2.
- **ADD overflow:** R1 = 0x7FFF, R2 = 0x0001, ADD R1, R2 (`0x0152`) → `rf[1]` = 0x8000, F = 1, N = 1, Z = 0, C = 0.
- **ADDUI vs ADDI extension:**
  - ADDUI R3, 0xFF on R3 = 0 → 0x00FF.
  - ADDI R4, 0xFF on R4 = 0 → 0xFFFF, N = 1.
- **CMP:** R5 = 3, R6 = 3, CMP R5, R6 (`0x05B6`) → `rf[5]` still 3, Z = 1. C and F keep their prior value, including after a preceding AND (no X ever in `psr`).
- **Illegal opcode and back-pressure:**
  - SUBC (`0x01A2`) → no write, `err` = 1, `done` pulses.
  - `in_valid` held high over 9 cycles with distinct words → exactly 3 accepted, in order.
- **Reset mid-operation:** ADD accepted, `reset_n` low during EXEC → no `done`, all `rf` = 0, `psr` = 0, `in_ready` = 1 after release.
